// File: rtl/mips_multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundle between the multicycle MIPS main control FSM and its datapath.
//   master modport : the controller (reads opcode/zero/mem_ready, drives all
//                    select lines, write enables, debug state, retired count
//                    and illegal flag)
//   slave modport  : the datapath side (the mirror image)
// Parameter CNT_WIDTH must match the controller's CNT_WIDTH.
// -----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if #(
   parameter int CNT_WIDTH = 32
);
   // datapath -> controller
   logic [5:0]           opcode;
   logic                 zero;
   logic                 mem_ready;

   // controller -> datapath
   logic                 pc_write;
   logic                 pc_write_cond;
   logic                 i_or_d;
   logic                 mem_read;
   logic                 mem_write;
   logic                 ir_write;
   logic                 mem_to_reg;
   logic                 reg_dst;
   logic                 reg_write;
   logic                 alu_src_a;
   logic [1:0]           alu_src_b;
   logic [1:0]           alu_op;
   logic [1:0]           pc_source;
   logic [3:0]           state_dbg;
   logic [CNT_WIDTH-1:0] retired;
   logic                 illegal;

   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, state_dbg, retired, illegal
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, state_dbg, retired, illegal
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore-style main control FSM for the multicycle MIPS datapath.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (state -> RESET, retired -> 0)
//   bus  - mips_multicycle_ctrl_if.master: opcode/zero/mem_ready in; PC, memory,
//          IR, register-file and ALU controls out, plus state_dbg, retired
//          (instruction counter, CNT_WIDTH bits) and illegal.
// Optional feature: define ILLEGAL_OP_TRAP_EN to send unrecognised opcodes to a
// sticky TRAP state that raises illegal. Without it they retire as NOPs and
// illegal is tied low.
// All controls are registered from the next state, except ir_write and the
// FETCH part of pc_write, which follow mem_ready combinationally in FETCH.
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   mips_multicycle_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_R_EXEC   = 4'd7,
      S_R_WB     = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_ADDI_EX  = 4'd11,
      S_ADDI_WB  = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   state_t               state_reg;
   state_t               state_next;
   ctrl_t                ctrl_reg;
   logic [CNT_WIDTH-1:0] retired_reg;
   logic                 retire;
   logic                 fetch_ready;
   logic                 unused_zero;

   // Branch resolution is done outside by gating pc_write_cond with zero.
   assign unused_zero = bus.zero;

   function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                         input logic ready);
      state_t n;
      n = S_FETCH;
      case (s)
         S_RESET:    n = S_FETCH;
         S_FETCH:    n = ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_RTYPE:     n = S_R_EXEC;
               OP_LW, OP_SW: n = S_MEM_ADDR;
               OP_BEQ:       n = S_BRANCH;
               OP_J:         n = S_JUMP;
               OP_ADDI:      n = S_ADDI_EX;
`ifdef ILLEGAL_OP_TRAP_EN
               default:      n = S_TRAP;
`else
               default:      n = S_FETCH;   // executed as a NOP
`endif
            endcase
         end
         S_MEM_ADDR: n = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   n = ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WB:   n = S_FETCH;
         S_MEM_WR:   n = ready ? S_FETCH : S_MEM_WR;
         S_R_EXEC:   n = S_R_WB;
         S_R_WB:     n = S_FETCH;
         S_BRANCH:   n = S_FETCH;
         S_JUMP:     n = S_FETCH;
         S_ADDI_EX:  n = S_ADDI_WB;
         S_ADDI_WB:  n = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
         S_TRAP:     n = S_TRAP;        // only rst leaves a trap
`else
         S_TRAP:     n = S_FETCH;       // unreachable; behaves like RESET
`endif
         default:    n = S_FETCH;       // 14/15 behave like RESET
      endcase
      return n;
   endfunction

   // Moore control word for a state; anything not set stays 0.
   function automatic ctrl_t ctrl_for(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE:   c.alu_src_b = 2'b10;
         S_MEM_ADDR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         S_R_WB: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
         end
         S_JUMP: begin
            c.pc_write  = 1'b1;
            c.pc_source = 2'b10;
         end
         S_ADDI_EX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_ADDI_WB:  c.reg_write = 1'b1;
         default:    c = '0;
      endcase
      return c;
   endfunction

   // States whose exit into FETCH completes an instruction. DECODE is listed
   // for the NOP path; with the trap enabled DECODE never returns to FETCH.
   function automatic logic completes(input state_t s);
      case (s)
         S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_DECODE:
            return 1'b1;
         default:
            return 1'b0;
      endcase
   endfunction

   assign state_next = next_state(state_reg, bus.opcode, bus.mem_ready);
   assign retire     = (state_next == S_FETCH) && completes(state_reg);

`ifdef ILLEGAL_OP_TRAP_EN
   logic illegal_reg;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= S_RESET;
         ctrl_reg    <= '0;
         retired_reg <= '0;
`ifdef ILLEGAL_OP_TRAP_EN
         illegal_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         ctrl_reg  <= ctrl_for(state_next);
         if (retire)
            retired_reg <= retired_reg + CNT_WIDTH'(1);
`ifdef ILLEGAL_OP_TRAP_EN
         illegal_reg <= (state_next == S_TRAP);
`endif
      end
   end

   // The only Mealy terms: IR load and PC increment fire when the fetch lands.
   assign fetch_ready = (state_reg == S_FETCH) && bus.mem_ready;

   assign bus.pc_write      = ctrl_reg.pc_write | fetch_ready;
   assign bus.ir_write      = fetch_ready;
   assign bus.pc_write_cond = ctrl_reg.pc_write_cond;
   assign bus.i_or_d        = ctrl_reg.i_or_d;
   assign bus.mem_read      = ctrl_reg.mem_read;
   assign bus.mem_write     = ctrl_reg.mem_write;
   assign bus.mem_to_reg    = ctrl_reg.mem_to_reg;
   assign bus.reg_dst       = ctrl_reg.reg_dst;
   assign bus.reg_write     = ctrl_reg.reg_write;
   assign bus.alu_src_a     = ctrl_reg.alu_src_a;
   assign bus.alu_src_b     = ctrl_reg.alu_src_b;
   assign bus.alu_op        = ctrl_reg.alu_op;
   assign bus.pc_source     = ctrl_reg.pc_source;
   assign bus.state_dbg     = state_reg;
   assign bus.retired       = retired_reg;
`ifdef ILLEGAL_OP_TRAP_EN
   assign bus.illegal       = illegal_reg;
`else
   assign bus.illegal       = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Directed bench for mips_multicycle_ctrl: walks R-type, lw (with memory wait
// states), fetch stall, sw, beq, j, addi, an unrecognised opcode, and a reset
// asserted in the middle of a load. Expected control words are hand-written.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   cyc;
   int   mark;

   mips_multicycle_ctrl_if #(.CNT_WIDTH(32)) bus ();

   mips_multicycle_ctrl #(.CNT_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed control word, packed in a fixed order for compact comparison.
   logic [16:0] ctrl_vec;
   assign ctrl_vec = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                      bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                      bus.pc_source, bus.illegal};

   function automatic logic [16:0] cv(
      input logic pw, input logic pwc, input logic iod, input logic mr,
      input logic mw, input logic irw, input logic m2r, input logic rdst,
      input logic rw, input logic asa, input logic [1:0] asb,
      input logic [1:0] aop, input logic [1:0] ps, input logic ill);
      return {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, ps, ill};
   endfunction

   logic [16:0] c_zero, c_fetch_rdy, c_fetch_wait, c_decode, c_mem_addr,
                c_mem_rd, c_mem_wb, c_mem_wr, c_r_exec, c_r_wb, c_branch,
                c_jump, c_addi_ex, c_addi_wb, c_trap;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_state(input string tag, input logic [3:0] st,
                               input logic [16:0] ctrl);
      check({tag, " state"}, 64'(bus.state_dbg), 64'(st));
      check({tag, " ctrl"}, 64'(ctrl_vec), 64'(ctrl));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      errors = 0;
      checks = 0;
      cyc    = 0;
      //                 pw pwc iod mr mw irw m2r rd rw asa asb    aop    ps     ill
      c_zero       = '0;
      c_fetch_rdy  = cv(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      c_fetch_wait = cv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
      c_decode     = cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 0);
      c_mem_addr   = cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      c_mem_rd     = cv(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      c_mem_wb     = cv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      c_mem_wr     = cv(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      c_r_exec     = cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0);
      c_r_wb       = cv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      c_branch     = cv(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
      c_jump       = cv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
      c_addi_ex    = cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
      c_addi_wb    = cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
      c_trap       = cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);

      // Reset, held across one clock edge, released mid-cycle.
      rst           = 1'b1;
      bus.opcode    = 6'b000000;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      @(posedge clk);
      #2;
      expect_state("reset_held", 4'd0, c_zero);
      check("reset_retired", 64'(bus.retired), 64'd0);
      rst = 1'b0;
      #1;
      expect_state("reset_released", 4'd0, c_zero);

      // RESET -> FETCH, fetch completes immediately.
      tick();
      expect_state("fetch0", 4'd1, c_fetch_rdy);
      check("fetch0_retired", 64'(bus.retired), 64'd0);

      // R-type: 1,2,7,8,1
      bus.opcode = 6'b000000;
      tick(); expect_state("r_decode", 4'd2, c_decode);
      tick(); expect_state("r_exec",   4'd7, c_r_exec);
      tick(); expect_state("r_wb",     4'd8, c_r_wb);
      tick(); expect_state("r_fetch",  4'd1, c_fetch_rdy);
      check("r_retired", 64'(bus.retired), 64'd1);
      mark = cyc;

      // lw with memory not ready for 3 cycles in MEM_RD, ready on the 4th.
      bus.opcode = 6'b100011;
      tick(); expect_state("lw_decode",   4'd2, c_decode);
      tick(); expect_state("lw_mem_addr", 4'd3, c_mem_addr);
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_state("lw_mem_rd", 4'd4, c_mem_rd);
         if (i == 3) bus.mem_ready = 1'b1;
      end
      tick(); expect_state("lw_mem_wb", 4'd5, c_mem_wb);
      tick(); expect_state("lw_fetch",  4'd1, c_fetch_rdy);
      check("lw_retired", 64'(bus.retired), 64'd2);
      check("lw_cycles", 64'(cyc - mark), 64'd8);

      // Fetch stall: ir_write/pc_write follow mem_ready, state holds.
      bus.mem_ready = 1'b0;
      #1; expect_state("fetch_stall", 4'd1, c_fetch_wait);
      tick(); expect_state("fetch_stall_hold", 4'd1, c_fetch_wait);
      bus.mem_ready = 1'b1;
      #1; expect_state("fetch_resume", 4'd1, c_fetch_rdy);

      // sw with one wait cycle in MEM_WR.
      bus.opcode = 6'b101011;
      tick(); expect_state("sw_decode",   4'd2, c_decode);
      tick(); expect_state("sw_mem_addr", 4'd3, c_mem_addr);
      bus.mem_ready = 1'b0;
      tick(); expect_state("sw_mem_wr",      4'd6, c_mem_wr);
      check("sw_wait_retired", 64'(bus.retired), 64'd2);
      tick(); expect_state("sw_mem_wr_hold", 4'd6, c_mem_wr);
      bus.mem_ready = 1'b1;
      tick(); expect_state("sw_fetch", 4'd1, c_fetch_rdy);
      check("sw_retired", 64'(bus.retired), 64'd3);

      // beq
      bus.opcode = 6'b000100;
      tick(); expect_state("beq_decode", 4'd2, c_decode);
      tick(); expect_state("beq_branch", 4'd9, c_branch);
      tick(); expect_state("beq_fetch",  4'd1, c_fetch_rdy);
      check("beq_retired", 64'(bus.retired), 64'd4);

      // j
      bus.opcode = 6'b000010;
      tick(); expect_state("j_decode", 4'd2,  c_decode);
      tick(); expect_state("j_jump",   4'd10, c_jump);
      tick(); expect_state("j_fetch",  4'd1,  c_fetch_rdy);
      check("j_retired", 64'(bus.retired), 64'd5);

      // addi
      bus.opcode = 6'b001000;
      tick(); expect_state("addi_decode", 4'd2,  c_decode);
      tick(); expect_state("addi_ex",     4'd11, c_addi_ex);
      tick(); expect_state("addi_wb",     4'd12, c_addi_wb);
      tick(); expect_state("addi_fetch",  4'd1,  c_fetch_rdy);
      check("addi_retired", 64'(bus.retired), 64'd6);

      // Unrecognised opcode.
      bus.opcode = 6'b111111;
      tick(); expect_state("ill_decode", 4'd2, c_decode);
`ifdef ILLEGAL_OP_TRAP_EN
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_state("ill_trap", 4'd13, c_trap);
         check("ill_trap_retired", 64'(bus.retired), 64'd6);
      end
      rst = 1'b1;
      #1; expect_state("ill_trap_rst", 4'd0, c_zero);
      tick();
      rst = 1'b0;
      tick(); expect_state("ill_after_rst", 4'd1, c_fetch_rdy);
      check("ill_after_rst_retired", 64'(bus.retired), 64'd0);
`else
      tick(); expect_state("ill_nop_fetch", 4'd1, c_fetch_rdy);
      check("ill_nop_retired", 64'(bus.retired), 64'd7);
      check("ill_flag", 64'(bus.illegal), 64'd0);
`endif

      // Reset asserted mid-cycle during MEM_RD of a load.
      bus.opcode = 6'b100011;
      tick(); expect_state("rst_lw_decode",   4'd2, c_decode);
      tick(); expect_state("rst_lw_mem_addr", 4'd3, c_mem_addr);
      bus.mem_ready = 1'b0;
      tick(); expect_state("rst_lw_mem_rd",   4'd4, c_mem_rd);
      #2;
      rst = 1'b1;
      #1;
      expect_state("rst_async", 4'd0, c_zero);
      check("rst_async_retired", 64'(bus.retired), 64'd0);
      bus.mem_ready = 1'b1;
      tick();
      expect_state("rst_hold", 4'd0, c_zero);
      check("rst_hold_reg_write", 64'(bus.reg_write), 64'd0);
      rst = 1'b0;
      tick();
      expect_state("rst_refetch", 4'd1, c_fetch_rdy);
      check("rst_refetch_retired", 64'(bus.retired), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
